// File: rtl/spi_master_ctrl_pkg.sv
// Shared encodings for the SPI initiator: command codes, FSM state codes and frame sizes.
package spi_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam int PAYLOAD_BITS = 10;
    localparam int DATA_BITS    = 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_SEL     = 3'd1;
    localparam state_t ST_SELBIT  = 3'd2;
    localparam state_t ST_SHIFT   = 3'd3;
    localparam state_t ST_WAIT_RD = 3'd4;
    localparam state_t ST_RECV    = 3'd5;
    localparam state_t ST_END     = 3'd6;

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Host request/response and serial lines of the SPI initiator, bundled as one interface.
interface spi_master_ctrl_if;

    logic       start;
    logic [1:0] cmd;
    logic [7:0] din;
    logic       MISO;
    logic       MOSI;
    logic       SS_n;
    logic       busy;
    logic       done;
    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (
        input  start,
        input  cmd,
        input  din,
        input  MISO,
        output MOSI,
        output SS_n,
        output busy,
        output done,
        output rx_data,
        output rx_valid
    );

    modport slave (
        output start,
        output cmd,
        output din,
        output MISO,
        input  MOSI,
        input  SS_n,
        input  busy,
        input  done,
        input  rx_data,
        input  rx_valid
    );

endinterface

// File: rtl/spi_master_ctrl_shifter.sv
// Datapath of the SPI initiator: TX shift register, RX shift register and the
// saturating down-counter that paces the SHIFT and RECV phases.
module spi_master_shifter
    import spi_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [PAYLOAD_BITS-1:0] load_word,
    input  logic                    tx_shift,
    input  logic                    rx_shift,
    input  logic                    miso,
    input  logic                    cnt_load,
    input  logic [3:0]              cnt_init,
    input  logic                    cnt_en,
    output logic                    tx_msb,
    output logic [DATA_BITS-1:0]    rx_word,
    output logic                    cnt_zero
);

    logic [PAYLOAD_BITS-1:0] tx_sr;
    logic [DATA_BITS-1:0]    rx_sr;
    logic [3:0]              cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_sr <= '0;
            rx_sr <= '0;
            cnt   <= '0;
        end else begin
            if (load) begin
                tx_sr <= load_word;
            end else if (tx_shift) begin
                tx_sr <= {tx_sr[PAYLOAD_BITS-2:0], 1'b0};
            end

            if (rx_shift) begin
                rx_sr <= {rx_sr[DATA_BITS-2:0], miso};
            end

            // Counter holds at zero rather than wrapping.
            if (cnt_load) begin
                cnt <= cnt_init;
            end else if (cnt_en && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    assign tx_msb   = tx_sr[PAYLOAD_BITS-1];
    assign rx_word  = rx_sr;
    assign cnt_zero = (cnt == 4'd0);

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI initiator for the SPI-slave RAM wrapper: one bit per clk, frames a 2-bit
// command plus 8-bit payload and returns the read word on rd_data frames.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | SS_n high, waiting for start
//   SEL     | drive SS_n low, MOSI 0 (slave leaves its idle state)
//   SELBIT  | drive cmd[1] as the read/write path select bit
//   SHIFT   | send {cmd,din} MSB first, 10 bits
//   WAIT_RD | rd_data only: RD_WAIT turnaround cycles, MOSI 0
//   RECV    | rd_data only: sample 8 MISO bits, MSB first
//   END     | SS_n high, done pulse on first cycle, GAP_CYCLES long
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int RD_WAIT    = 2,
    parameter int GAP_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    spi_master_ctrl_if.master   bus
);

    localparam logic [3:0] WAIT_INIT = 4'(RD_WAIT - 1);
    localparam logic [3:0] GAP_INIT  = 4'(GAP_CYCLES - 1);
    localparam logic [3:0] BIT_INIT  = 4'(PAYLOAD_BITS - 1);
    localparam logic [3:0] RX_INIT   = 4'(DATA_BITS - 1);

    state_t               state;
    logic [3:0]           wait_cnt;
    logic                 first_end;
    logic                 is_rd;
    logic                 ss_n_q;
    logic                 mosi_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 rx_valid_q;
    logic [DATA_BITS-1:0] rx_data_q;

    logic                 accept;
    logic                 cnt_load;
    logic [3:0]           cnt_init;
    logic                 cnt_en;
    logic                 tx_msb;
    logic [DATA_BITS-1:0] rx_word;
    logic                 cnt_zero;

    // The last END cycle also accepts a request, so a held start chains
    // frames with exactly GAP_CYCLES of SS_n high between them.
    assign accept = bus.start &&
                    ((state == ST_IDLE) || ((state == ST_END) && (wait_cnt == 4'd0)));

    always_comb begin
        cnt_load = 1'b0;
        cnt_init = BIT_INIT;
        if (state == ST_SELBIT) begin
            cnt_load = 1'b1;
            cnt_init = BIT_INIT;
        end else if ((state == ST_WAIT_RD) && (wait_cnt == 4'd0)) begin
            cnt_load = 1'b1;
            cnt_init = RX_INIT;
        end
    end

    assign cnt_en = (state == ST_SHIFT) || (state == ST_RECV);

    spi_master_shifter u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .load_word ({bus.cmd, bus.din}),
        .tx_shift  (state == ST_SHIFT),
        .rx_shift  (state == ST_RECV),
        .miso      (bus.MISO),
        .cnt_load  (cnt_load),
        .cnt_init  (cnt_init),
        .cnt_en    (cnt_en),
        .tx_msb    (tx_msb),
        .rx_word   (rx_word),
        .cnt_zero  (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            first_end  <= 1'b0;
            is_rd      <= 1'b0;
            ss_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            done_q     <= 1'b0;
            rx_valid_q <= 1'b0;

            case (state)
                ST_IDLE: begin
                    ss_n_q <= 1'b1;
                    mosi_q <= 1'b0;
                    if (accept) begin
                        state  <= ST_SEL;
                        busy_q <= 1'b1;
                        is_rd  <= (bus.cmd == CMD_RD_DATA);
                    end else begin
                        busy_q <= 1'b0;
                    end
                end

                ST_SEL: begin
                    ss_n_q <= 1'b0;
                    mosi_q <= 1'b0;
                    state  <= ST_SELBIT;
                end

                ST_SELBIT: begin
                    mosi_q <= tx_msb;
                    state  <= ST_SHIFT;
                end

                ST_SHIFT: begin
                    mosi_q <= tx_msb;
                    if (cnt_zero) begin
                        if (is_rd) begin
                            state    <= ST_WAIT_RD;
                            wait_cnt <= WAIT_INIT;
                        end else begin
                            state     <= ST_END;
                            wait_cnt  <= GAP_INIT;
                            first_end <= 1'b1;
                        end
                    end
                end

                ST_WAIT_RD: begin
                    mosi_q <= 1'b0;
                    if (wait_cnt == 4'd0) begin
                        state <= ST_RECV;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                ST_RECV: begin
                    mosi_q <= 1'b0;
                    if (cnt_zero) begin
                        state     <= ST_END;
                        wait_cnt  <= GAP_INIT;
                        first_end <= 1'b1;
                    end
                end

                ST_END: begin
                    ss_n_q    <= 1'b1;
                    mosi_q    <= 1'b0;
                    first_end <= 1'b0;
                    if (first_end) begin
                        done_q <= 1'b1;
                        if (is_rd) begin
                            rx_valid_q <= 1'b1;
                            rx_data_q  <= rx_word;
                        end
                    end
                    if (wait_cnt == 4'd0) begin
                        if (accept) begin
                            state  <= ST_SEL;
                            busy_q <= 1'b1;
                            is_rd  <= (bus.cmd == CMD_RD_DATA);
                        end else begin
                            state  <= ST_IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                default: begin
                    state  <= ST_IDLE;
                    ss_n_q <= 1'b1;
                    mosi_q <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.MOSI     = mosi_q;
    assign bus.SS_n     = ss_n_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: table of frames against a tiny model of the
// RAM wrapper, plus hand sequences for reset, mid-frame reset and chained frames.
module tb_spi_master_ctrl;

    localparam int RW  = 2;
    localparam int LIM = 26;

    typedef struct {
        logic [1:0]  cmd;
        logic [7:0]  din;
        int          inj;
        logic [10:0] mosi;
        int          done_edge;
        logic [7:0]  rx;
        logic        rxv;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total  = 0;

    logic [7:0] mem [256];
    logic [7:0] wa;
    logic [7:0] ra;

    spi_master_ctrl_if bus ();

    spi_master_ctrl #(.RD_WAIT(RW), .GAP_CYCLES(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [10:0] mosi_got;
        logic [7:0]  miso_word;
        logic [7:0]  rx_at_done;
        logic        rxv_at_done;
        logic        ss_ok;
        int          done_edge;
        int          done_cnt;
        int          rxv_cnt;
        mosi_got    = '0;
        rx_at_done  = 8'h00;
        rxv_at_done = 1'b0;
        ss_ok       = 1'b1;
        done_edge   = -1;
        done_cnt    = 0;
        rxv_cnt     = 0;
        miso_word   = (v.cmd == 2'b11) ? mem[ra] : 8'h00;

        @(negedge clk);
        bus.start = 1'b1;
        bus.cmd   = v.cmd;
        bus.din   = v.din;
        @(posedge clk);
        for (int k = 1; k <= LIM; k++) begin
            @(negedge clk);
            bus.start = (v.inj != 0) && (k == v.inj);
            if (bus.start) begin
                bus.cmd = 2'b01;
                bus.din = 8'hFF;
            end
            if (v.cmd == 2'b11 && k >= 13 + RW && k <= 20 + RW)
                bus.MISO = miso_word[7 - (k - 13 - RW)];
            else
                bus.MISO = 1'b0;
            @(posedge clk);
            #1;
            if (k >= 2 && k <= 12) mosi_got[12 - k] = bus.MOSI;
            if (bus.SS_n !== (k >= v.done_edge)) ss_ok = 1'b0;
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_edge < 0) begin
                    done_edge   = k;
                    rxv_at_done = bus.rx_valid;
                    rx_at_done  = bus.rx_data;
                end
            end
            if (bus.rx_valid === 1'b1) rxv_cnt++;
        end

        check($sformatf("v%0d mosi", idx), 32'(mosi_got), 32'(v.mosi));
        check($sformatf("v%0d ss_n window", idx), 32'(ss_ok), 32'd1);
        check($sformatf("v%0d done edge", idx), done_edge, v.done_edge);
        check($sformatf("v%0d done count", idx), done_cnt, 1);
        check($sformatf("v%0d rx_data", idx), 32'(rx_at_done), 32'(v.rx));
        check($sformatf("v%0d rx_valid at done", idx), 32'(rxv_at_done), 32'(v.rxv));
        check($sformatf("v%0d rx_valid count", idx), rxv_cnt, int'(v.rxv));

        case (v.cmd)
            2'b00:   wa = v.din;
            2'b01:   mem[wa] = v.din;
            2'b10:   ra = v.din;
            default: ;
        endcase
    endtask

    vec_t vt [9];
    vec_t vpost;

    logic ss_log   [0:40];
    logic mosi_log [0:40];
    logic done_log [0:40];
    logic busy_log [0:40];

    initial begin
        int dcnt;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        wa = 8'h00;
        ra = 8'h00;

        //          cmd    din    inj  mosi {sel,cmd,din}   done     rx     rxv
        vt[0] = '{2'b00, 8'h0A, 0, 11'b0_00_00001010, 13,      8'h00, 1'b0};
        vt[1] = '{2'b01, 8'h5A, 0, 11'b0_01_01011010, 13,      8'h00, 1'b0};
        vt[2] = '{2'b10, 8'h0A, 0, 11'b1_10_00001010, 13,      8'h00, 1'b0};
        vt[3] = '{2'b11, 8'h00, 0, 11'b1_11_00000000, 13+RW+8, 8'h5A, 1'b1};
        vt[4] = '{2'b00, 8'h33, 5, 11'b0_00_00110011, 13,      8'h5A, 1'b0};
        vt[5] = '{2'b01, 8'hB4, 0, 11'b0_01_10110100, 13,      8'h5A, 1'b0};
        vt[6] = '{2'b10, 8'h33, 0, 11'b1_10_00110011, 13,      8'h5A, 1'b0};
        vt[7] = '{2'b11, 8'h00, 0, 11'b1_11_00000000, 13+RW+8, 8'hB4, 1'b1};
        vt[8] = '{2'b11, 8'h5C, 0, 11'b1_11_01011100, 13+RW+8, 8'hB4, 1'b1};
        vpost = '{2'b00, 8'h0A, 0, 11'b0_00_00001010, 13,      8'h00, 1'b0};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.cmd   = 2'b00;
        bus.din   = 8'h00;
        bus.MISO  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset SS_n", 32'(bus.SS_n), 32'd1);
        check("reset MOSI", 32'(bus.MOSI), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset rx_data", 32'(bus.rx_data), 32'h00);
        check("reset rx_valid", 32'(bus.rx_valid), 32'd0);

        for (int i = 0; i < 9; i++) run_vec(vt[i], i);

        // Reset in the middle of a wr_data frame: abort, no done.
        @(negedge clk);
        bus.start = 1'b1;
        bus.cmd   = 2'b01;
        bus.din   = 8'h77;
        @(posedge clk);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            @(posedge clk);
        end
        #1;
        check("midrst SS_n low before rst", 32'(bus.SS_n), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst SS_n", 32'(bus.SS_n), 32'd1);
        check("midrst MOSI", 32'(bus.MOSI), 32'd0);
        check("midrst busy", 32'(bus.busy), 32'd0);
        check("midrst rx_data", 32'(bus.rx_data), 32'h00);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) dcnt++;
        end
        check("midrst no done", dcnt, 0);
        run_vec(vpost, 9);

        // Start held high: frame 1 wr_addr, frame 2 rd_addr chained.
        @(negedge clk);
        bus.start = 1'b1;
        bus.cmd   = 2'b00;
        bus.din   = 8'h0A;
        @(posedge clk);
        dcnt = 0;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.cmd = 2'b10;
                bus.din = 8'h3C;
            end
            if (k == 15) bus.start = 1'b0;
            bus.MISO = 1'b0;
            @(posedge clk);
            #1;
            ss_log[k]   = bus.SS_n;
            mosi_log[k] = bus.MOSI;
            done_log[k] = bus.done;
            busy_log[k] = bus.busy;
            if (bus.done === 1'b1) dcnt++;
        end
        check("b2b SS_n edge12", 32'(ss_log[12]), 32'd0);
        check("b2b SS_n edge13", 32'(ss_log[13]), 32'd1);
        check("b2b SS_n edge14", 32'(ss_log[14]), 32'd0);
        check("b2b done edge13", 32'(done_log[13]), 32'd1);
        check("b2b busy edge13", 32'(busy_log[13]), 32'd1);
        check("b2b MOSI edge14", 32'(mosi_log[14]), 32'd0);
        check("b2b select bit edge15", 32'(mosi_log[15]), 32'd1);
        check("b2b cmd bits edge16/17", {30'd0, mosi_log[16], mosi_log[17]}, 32'b10);
        check("b2b done edge26", 32'(done_log[26]), 32'd1);
        check("b2b done count", dcnt, 2);
        check("b2b busy idle", 32'(busy_log[34]), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
